// File: rtl/hist_bin_accum.sv
// hist_bin_accum: one-channel 256-bin histogram builder with ping-pong bin banks.
//   Counts pixel values (img_data) of each active frame into the write bank.
//   At frame end it pulses ram_hist_done and swaps banks. It then clears the
//   new write bank while serving reads from the completed bank.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   img_data/hs/vs      pixel stream; pixel valid when img_hs && img_vs
//   ram_hist_done       1-cycle pulse on bank swap
//   dr_ram_rd_*         1-cycle-latency read port on the read bank (addr >= 256 reads 0)
//   frame_pix_cnt       accepted pixels of the last completed frame
//   hist_overrun        sticky flag: in-frame pixel dropped while clearing
module hist_bin_accum #(
  parameter int unsigned BIN_W   = 32,
  parameter int unsigned CLR_CYC = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       img_data,
  input  logic             img_hs,
  input  logic             img_vs,
  output logic             ram_hist_done,
  input  logic             dr_ram_rd_en,
  input  logic [8:0]       dr_ram_rd_addr,
  output logic             dr_ram_rd_valid,
  output logic [BIN_W-1:0] dr_ram_rd_dout,
  output logic [31:0]      frame_pix_cnt,
  output logic             hist_overrun
);

  typedef enum logic [2:0] {ST_CLEAR, ST_IDLE, ST_ACCUM, ST_DRAIN, ST_SWAP} state_t;

  localparam logic [7:0] CLR_LAST = 8'(CLR_CYC - 1);

  logic [BIN_W-1:0] bank0 [256];
  logic [BIN_W-1:0] bank1 [256];

  state_t           state_q, state_d;
  logic [7:0]       clr_cnt_q, clr_cnt_d;
  logic             clr_both_q, clr_both_d;
  logic             wr_bank_q, wr_bank_d;
  logic             s1_vld_q, s1_vld_d;
  logic [7:0]       s1_bin_q, s1_bin_d;
  logic             s2_vld_q, s2_vld_d;
  logic [7:0]       s2_bin_q, s2_bin_d;
  logic [BIN_W-1:0] s2_cnt_q, s2_cnt_d;
  logic [31:0]      pix_cnt_q, pix_cnt_d;
  logic [31:0]      frame_cnt_q, frame_cnt_d;
  logic             overrun_q, overrun_d;
  logic             seen_done_q, seen_done_d;
  logic             rd_valid_q, rd_valid_d;
  logic [BIN_W-1:0] rd_dout_q, rd_dout_d;

  logic             accept, pix_in, done;
  logic             we0, we1;
  logic [7:0]       waddr;
  logic [BIN_W-1:0] wdata, s2_new, rd_fwd, rd_bank_data;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clr_both_d   = clr_both_q;
    wr_bank_d    = wr_bank_q;
    pix_cnt_d    = pix_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    overrun_d    = overrun_q;
    seen_done_d  = seen_done_q;
    accept       = 1'b0;
    done         = 1'b0;
    pix_in       = img_hs && img_vs;

    // Write stage: saturating increment of the value captured by the read stage.
    s2_new = (s2_cnt_q == '1) ? s2_cnt_q : s2_cnt_q + BIN_W'(1);
    we0    = s2_vld_q && !wr_bank_q;
    we1    = s2_vld_q &&  wr_bank_q;
    waddr  = s2_bin_q;
    wdata  = s2_new;

    // Read stage: the write stage commits at the end of this cycle, so a
    // same-bin predecessor must be taken from s2_new rather than the bank.
    if (s2_vld_q && (s2_bin_q == s1_bin_q)) begin
      rd_fwd = s2_new;
    end else begin
      rd_fwd = wr_bank_q ? bank1[s1_bin_q] : bank0[s1_bin_q];
    end

    unique case (state_q)
      ST_CLEAR: begin
        waddr     = clr_cnt_q;
        wdata     = '0;
        we0       = clr_both_q || !wr_bank_q;
        we1       = clr_both_q ||  wr_bank_q;
        clr_cnt_d = clr_cnt_q + 8'd1;
        if (pix_in) overrun_d = 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d  = '0;
          clr_both_d = 1'b0;
          state_d    = img_vs ? ST_ACCUM : ST_IDLE;
        end
      end
      ST_IDLE: begin
        // IDLE is only entered with img_vs low, so img_vs high here is the rising edge.
        if (img_vs) begin
          accept  = pix_in;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (!img_vs) state_d = ST_DRAIN;
        else         accept  = pix_in;
      end
      ST_DRAIN: begin
        if (!s1_vld_q && !s2_vld_q) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        done        = 1'b1;
        wr_bank_d   = !wr_bank_q;
        frame_cnt_d = pix_cnt_q;
        pix_cnt_d   = '0;
        seen_done_d = 1'b1;
        state_d     = ST_CLEAR;
      end
      default: state_d = ST_CLEAR;
    endcase

    if (accept && (pix_cnt_q != '1)) pix_cnt_d = pix_cnt_q + 32'd1;

    s1_vld_d = accept;
    s1_bin_d = img_data;
    s2_vld_d = s1_vld_q;
    s2_bin_d = s1_bin_q;
    s2_cnt_d = rd_fwd;

    rd_bank_data = wr_bank_q ? bank0[dr_ram_rd_addr[7:0]] : bank1[dr_ram_rd_addr[7:0]];
    rd_valid_d   = dr_ram_rd_en;
    rd_dout_d    = rd_dout_q;
    if (dr_ram_rd_en) begin
      rd_dout_d = (!dr_ram_rd_addr[8] && seen_done_q) ? rd_bank_data : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (we0) bank0[waddr] <= wdata;
    if (we1) bank1[waddr] <= wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      clr_both_q  <= 1'b1;
      wr_bank_q   <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_bin_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_bin_q    <= '0;
      s2_cnt_q    <= '0;
      pix_cnt_q   <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
      seen_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_dout_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_both_q  <= clr_both_d;
      wr_bank_q   <= wr_bank_d;
      s1_vld_q    <= s1_vld_d;
      s1_bin_q    <= s1_bin_d;
      s2_vld_q    <= s2_vld_d;
      s2_bin_q    <= s2_bin_d;
      s2_cnt_q    <= s2_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      seen_done_q <= seen_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_dout_q   <= rd_dout_d;
    end
  end

  assign ram_hist_done   = done;
  assign dr_ram_rd_valid = rd_valid_q;
  assign dr_ram_rd_dout  = rd_dout_q;
  assign frame_pix_cnt   = frame_cnt_q;
  assign hist_overrun    = overrun_q;

endmodule
